// File: rtl/mesh_hs_pkg.sv
// Shared types and constants for the mesh handshake monitor.
// Holds the per-channel FSM states and the error-flag bit positions.
package mesh_hs_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        TOUT = 2'd2
    } hs_state_t;

    localparam int WAIT_W   = 10;
    localparam int NUM_ERR  = 4;
    localparam int ERR_TOUT = 0;
    localparam int ERR_UNST = 1;
    localparam int ERR_DROP = 2;
    localparam int ERR_SPUR = 3;

endpackage

// File: rtl/mesh_hs_if.sv
// Bundle of the monitored pndng/pop/data handshake lines.
// The producer/consumer side drives it; the monitor only observes.
interface mesh_hs_if #(
    parameter int CHANNELS = 16,
    parameter int PCKG_SZ  = 40
);

    logic [CHANNELS-1:0]         pndng;
    logic [CHANNELS-1:0]         pop;
    logic [CHANNELS*PCKG_SZ-1:0] data;

    modport master (output pndng, output pop, output data);
    modport slave  (input  pndng, input  pop, input  data);

endinterface

// File: rtl/mesh_hs_chan.sv
// Single-channel handshake checker: FSM, wait counter, data capture,
// sticky error flags and a saturating transfer counter.
module mesh_hs_chan
    import mesh_hs_pkg::*;
#(
    parameter int PCKG_SZ = 40,
    parameter int TIMEOUT = 50,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pndng,
    input  logic               pop,
    input  logic [PCKG_SZ-1:0] data,
    input  logic               clr_err,
    input  logic               clr_cnt,
    output logic [NUM_ERR-1:0] err,
    output logic [CNT_W-1:0]   xfer_cnt
);

    localparam logic [WAIT_W-1:0] TOUT_V = WAIT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  CMAX   = '1;

    hs_state_t          state, state_n;
    logic [WAIT_W-1:0]  wcnt, wcnt_n;
    logic [PCKG_SZ-1:0] cap, cap_n;
    logic [NUM_ERR-1:0] ev;
    logic               xfer;
    logic [CNT_W-1:0]   cnt_base;

    always_comb begin
        state_n = state;
        wcnt_n  = wcnt;
        cap_n   = cap;
        ev      = '0;
        xfer    = 1'b0;
        unique case (state)
            IDLE: begin
                if (pndng && pop) begin
                    xfer = 1'b1;
                end else if (pndng) begin
                    cap_n   = data;
                    wcnt_n  = WAIT_W'(1);
                    state_n = WAIT;
                end else if (pop) begin
                    ev[ERR_SPUR] = 1'b1;
                end
            end
            WAIT, TOUT: begin
                // Stability is judged even on the pop edge
                if (pndng && (data != cap))
                    ev[ERR_UNST] = 1'b1;
                if (pop) begin
                    xfer    = 1'b1;
                    state_n = IDLE;
                end else if (!pndng) begin
                    ev[ERR_DROP] = 1'b1;
                    state_n      = IDLE;
                end else if (state == WAIT) begin
                    wcnt_n = wcnt + 1'b1;
                    if (wcnt_n == TOUT_V) begin
                        ev[ERR_TOUT] = 1'b1;
                        state_n      = TOUT;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign cnt_base = clr_cnt ? '0 : xfer_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            wcnt     <= '0;
            cap      <= '0;
            err      <= '0;
            xfer_cnt <= '0;
        end else begin
            state    <= state_n;
            wcnt     <= wcnt_n;
            cap      <= cap_n;
            err      <= (clr_err ? '0 : err) | ev;
            xfer_cnt <= (xfer && cnt_base != CMAX) ? cnt_base + 1'b1
                                                   : cnt_base;
        end
    end

endmodule

// File: rtl/mesh_hs_monitor.sv
// Multi-channel pndng/pop handshake monitor with sticky error flags,
// per-channel transfer counters and a combined interrupt.
module mesh_hs_monitor
    import mesh_hs_pkg::*;
#(
    parameter int CHANNELS = 16,
    parameter int PCKG_SZ  = 40,
    parameter int TIMEOUT  = 50,
    parameter int CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    mesh_hs_if.slave                  hs,
    input  logic                      clr_err,
    input  logic                      clr_cnt,
    output logic [CHANNELS-1:0]       err_timeout,
    output logic [CHANNELS-1:0]       err_unstable,
    output logic [CHANNELS-1:0]       err_drop,
    output logic [CHANNELS-1:0]       err_spurious,
    output logic [CHANNELS*CNT_W-1:0] xfer_cnt,
    output logic                      irq
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [NUM_ERR-1:0] err;

        mesh_hs_chan #(
            .PCKG_SZ (PCKG_SZ),
            .TIMEOUT (TIMEOUT),
            .CNT_W   (CNT_W)
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .pndng    (hs.pndng[i]),
            .pop      (hs.pop[i]),
            .data     (hs.data[i*PCKG_SZ +: PCKG_SZ]),
            .clr_err  (clr_err),
            .clr_cnt  (clr_cnt),
            .err      (err),
            .xfer_cnt (xfer_cnt[i*CNT_W +: CNT_W])
        );

        assign err_timeout[i]  = err[ERR_TOUT];
        assign err_unstable[i] = err[ERR_UNST];
        assign err_drop[i]     = err[ERR_DROP];
        assign err_spurious[i] = err[ERR_SPUR];
    end

    assign irq = |{err_timeout, err_unstable, err_drop, err_spurious};

endmodule

// File: tb/tb_mesh_hs_monitor.sv
// Bench for mesh_hs_monitor: vector table, directed corner cases and
// randomized traffic against a transaction-level reference model.
module tb_mesh_hs_monitor;

    localparam int CH = 16;
    localparam int PW = 40;
    localparam int TO = 50;
    localparam int CW = 16;
    localparam int CH2 = 2;
    localparam int PW2 = 8;
    localparam int CW2 = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic clr_err = 1'b0;
    logic clr_cnt = 1'b0;

    always #5 clk = ~clk;

    mesh_hs_if #(.CHANNELS(CH), .PCKG_SZ(PW)) hs ();
    mesh_hs_if #(.CHANNELS(CH2), .PCKG_SZ(PW2)) hs2 ();

    logic [CH-1:0]    err_timeout, err_unstable, err_drop, err_spurious;
    logic [CH*CW-1:0] xfer_cnt;
    logic             irq;

    logic [CH2-1:0]     e2_to, e2_un, e2_dr, e2_sp;
    logic [CH2*CW2-1:0] xfer_cnt2;
    logic               irq2;

    mesh_hs_monitor #(
        .CHANNELS(CH), .PCKG_SZ(PW), .TIMEOUT(TO), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .hs(hs),
        .clr_err(clr_err), .clr_cnt(clr_cnt),
        .err_timeout(err_timeout), .err_unstable(err_unstable),
        .err_drop(err_drop), .err_spurious(err_spurious),
        .xfer_cnt(xfer_cnt), .irq(irq)
    );

    mesh_hs_monitor #(
        .CHANNELS(CH2), .PCKG_SZ(PW2), .TIMEOUT(TO), .CNT_W(CW2)
    ) dut2 (
        .clk(clk), .reset(reset), .hs(hs2),
        .clr_err(clr_err), .clr_cnt(clr_cnt),
        .err_timeout(e2_to), .err_unstable(e2_un),
        .err_drop(e2_dr), .err_spurious(e2_sp),
        .xfer_cnt(xfer_cnt2), .irq(irq2)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] fl(int c);
        return {err_spurious[c], err_drop[c], err_unstable[c], err_timeout[c]};
    endfunction

    function automatic logic [CW-1:0] cnt_of(int c);
        return xfer_cnt[c*CW +: CW];
    endfunction

    task automatic all_zero(string tag);
        chk({tag, "_to"}, 256'(err_timeout), 256'(0));
        chk({tag, "_un"}, 256'(err_unstable), 256'(0));
        chk({tag, "_dr"}, 256'(err_drop), 256'(0));
        chk({tag, "_sp"}, 256'(err_spurious), 256'(0));
        chk({tag, "_cnt"}, 256'(xfer_cnt), 256'(0));
        chk({tag, "_irq"}, 256'(irq), 256'(0));
    endtask

    typedef struct {
        int         ch;
        bit         pn;
        bit         pp;
        logic [7:0] d;
        bit         ce;
        bit         cc;
        logic [3:0] ef;
        int         ec;
        bit         ei;
    } vec_t;

    vec_t tv[$];

    // Reference model: request outstanding flag, age of the request
    bit         m_pend[CH];
    int         m_age[CH];
    logic [PW-1:0] m_cap[CH];
    logic [3:0] m_f[CH];
    int         m_cnt[CH];

    task automatic mdl_reset();
        for (int c = 0; c < CH; c++) begin
            m_pend[c] = 0;
            m_age[c]  = 0;
            m_cap[c]  = '0;
            m_f[c]    = '0;
            m_cnt[c]  = 0;
        end
    endtask

    task automatic mdl_step();
        for (int c = 0; c < CH; c++) begin
            logic [3:0]    ev;
            bit            x;
            bit            pn;
            bit            pp;
            logic [PW-1:0] d;
            int            base;
            ev = '0;
            x  = 0;
            pn = hs.pndng[c];
            pp = hs.pop[c];
            d  = hs.data[c*PW +: PW];
            if (!m_pend[c]) begin
                if (pn && pp) x = 1;
                else if (pn) begin
                    m_pend[c] = 1;
                    m_age[c]  = 1;
                    m_cap[c]  = d;
                end else if (pp) ev[3] = 1;
            end else begin
                if (pn && d != m_cap[c]) ev[1] = 1;
                if (pp) begin
                    x = 1;
                    m_pend[c] = 0;
                end else if (!pn) begin
                    ev[2] = 1;
                    m_pend[c] = 0;
                end else if (m_age[c] < TO) begin
                    m_age[c]++;
                    if (m_age[c] == TO) ev[0] = 1;
                end
            end
            m_f[c] = (clr_err ? 4'b0 : m_f[c]) | ev;
            base = clr_cnt ? 0 : m_cnt[c];
            if (x && base < (1 << CW) - 1) base++;
            m_cnt[c] = base;
        end
    endtask

    task automatic mdl_check(int cyc);
        logic [CH-1:0]    et, eu, ed, es;
        logic [CH*CW-1:0] ecnt;
        for (int c = 0; c < CH; c++) begin
            et[c] = m_f[c][0];
            eu[c] = m_f[c][1];
            ed[c] = m_f[c][2];
            es[c] = m_f[c][3];
            ecnt[c*CW +: CW] = CW'(m_cnt[c]);
        end
        chk($sformatf("rnd%0d_to", cyc), 256'(err_timeout), 256'(et));
        chk($sformatf("rnd%0d_un", cyc), 256'(err_unstable), 256'(eu));
        chk($sformatf("rnd%0d_dr", cyc), 256'(err_drop), 256'(ed));
        chk($sformatf("rnd%0d_sp", cyc), 256'(err_spurious), 256'(es));
        chk($sformatf("rnd%0d_cnt", cyc), 256'(xfer_cnt), 256'(ecnt));
        chk($sformatf("rnd%0d_irq", cyc), 256'(irq),
            256'(|{et, eu, ed, es}));
    endtask

    initial begin
        hs.pndng = '0; hs.pop = '0; hs.data = '0;
        hs2.pndng = '0; hs2.pop = '0; hs2.data = '0;

        repeat (2) tick();
        all_zero("reset");
        #3 reset = 1'b0;

        // ch, pn, pop, data, clr_err, clr_cnt, flags{sp,dr,un,to}, cnt, irq
        tv.push_back('{7, 0, 1, 8'h00, 0, 0, 4'b1000, 0, 1});
        tv.push_back('{7, 0, 0, 8'h00, 1, 0, 4'b0000, 0, 0});
        tv.push_back('{6, 1, 0, 8'h11, 0, 0, 4'b0000, 0, 0});
        tv.push_back('{6, 1, 0, 8'h11, 0, 0, 4'b0000, 0, 0});
        tv.push_back('{6, 0, 0, 8'h11, 0, 0, 4'b0100, 0, 1});
        tv.push_back('{6, 0, 0, 8'h11, 1, 0, 4'b0000, 0, 0});
        tv.push_back('{5, 1, 0, 8'h0A, 0, 0, 4'b0000, 0, 0});
        tv.push_back('{5, 1, 0, 8'h0A, 0, 0, 4'b0000, 0, 0});
        tv.push_back('{5, 1, 0, 8'h0A, 0, 0, 4'b0000, 0, 0});
        tv.push_back('{5, 1, 0, 8'h0B, 0, 0, 4'b0010, 0, 1});
        tv.push_back('{5, 1, 1, 8'h0B, 0, 0, 4'b0010, 1, 1});
        tv.push_back('{5, 0, 0, 8'h0B, 0, 0, 4'b0010, 1, 1});
        tv.push_back('{5, 0, 0, 8'h0B, 1, 0, 4'b0000, 1, 0});
        tv.push_back('{9, 0, 1, 8'h00, 0, 0, 4'b1000, 0, 1});
        tv.push_back('{9, 1, 0, 8'h22, 0, 0, 4'b1000, 0, 1});
        tv.push_back('{9, 0, 0, 8'h22, 1, 0, 4'b0100, 0, 1});
        tv.push_back('{9, 0, 0, 8'h22, 1, 0, 4'b0000, 0, 0});
        tv.push_back('{9, 1, 1, 8'h22, 0, 0, 4'b0000, 1, 0});
        tv.push_back('{9, 1, 1, 8'h22, 0, 0, 4'b0000, 2, 0});
        tv.push_back('{9, 1, 1, 8'h22, 0, 1, 4'b0000, 1, 0});

        foreach (tv[i]) begin
            hs.pndng = '0;
            hs.pop   = '0;
            hs.pndng[tv[i].ch] = tv[i].pn;
            hs.pop[tv[i].ch]   = tv[i].pp;
            hs.data[tv[i].ch*PW +: PW] = PW'(tv[i].d);
            clr_err = tv[i].ce;
            clr_cnt = tv[i].cc;
            tick();
            chk($sformatf("tv%0d_flags", i), 256'(fl(tv[i].ch)), 256'(tv[i].ef));
            chk($sformatf("tv%0d_cnt", i), 256'(cnt_of(tv[i].ch)), 256'(tv[i].ec));
            chk($sformatf("tv%0d_irq", i), 256'(irq), 256'(tv[i].ei));
        end
        hs.pndng = '0; hs.pop = '0;
        clr_err = 0; clr_cnt = 0;

        // ch3: pop ten cycles after pndng rises
        hs.pndng[3] = 1; hs.data[3*PW +: PW] = PW'(8'h33);
        repeat (10) tick();
        hs.pop[3] = 1;
        tick();
        hs.pndng[3] = 0; hs.pop[3] = 0;
        tick();
        chk("ch3_cnt", 256'(cnt_of(3)), 256'(1));
        chk("ch3_flags", 256'({err_timeout, err_unstable, err_drop, err_spurious}), 256'(0));
        chk("ch3_irq", 256'(irq), 256'(0));

        // ch0: timeout boundary, late pop, then clear
        hs.pndng[0] = 1; hs.data[0 +: PW] = PW'(8'h05);
        for (int k = 1; k <= 59; k++) begin
            tick();
            if (k == TO - 1) chk("ch0_to_before", 256'(err_timeout[0]), 256'(0));
            if (k == TO) begin
                chk("ch0_to_at", 256'(err_timeout[0]), 256'(1));
                chk("ch0_irq_at", 256'(irq), 256'(1));
            end
        end
        hs.pop[0] = 1;
        tick();
        chk("ch0_cnt", 256'(cnt_of(0)), 256'(1));
        chk("ch0_to_held", 256'(err_timeout[0]), 256'(1));
        hs.pndng[0] = 0; hs.pop[0] = 0; clr_err = 1;
        tick();
        clr_err = 0;
        chk("ch0_to_clr", 256'(err_timeout[0]), 256'(0));
        chk("ch0_irq_clr", 256'(irq), 256'(0));

        // ch2: reset in the middle of a wait
        hs.pndng[2] = 1; hs.data[2*PW +: PW] = PW'(8'h44);
        repeat (20) tick();
        chk("ch2_pre_irq", 256'(irq), 256'(0));
        #2 reset = 1'b1;
        #1 all_zero("async_rst");
        hs.pndng[2] = 0;
        #2 reset = 1'b0;
        tick();
        all_zero("post_rst");
        hs.pndng[2] = 1; hs.pop[2] = 1;
        tick();
        hs.pndng[2] = 0; hs.pop[2] = 0;
        chk("ch2_first_edge", 256'(cnt_of(2)), 256'(1));
        chk("ch2_first_flags", 256'(fl(2)), 256'(0));

        // narrow counter saturates on dut2 channel 1
        hs2.pndng[1] = 1; hs2.pop[1] = 1;
        for (int k = 1; k <= 17; k++) begin
            tick();
            if (k == 14) chk("sat_14", 256'(xfer_cnt2[CW2 +: CW2]), 256'(14));
            if (k == 15) chk("sat_15", 256'(xfer_cnt2[CW2 +: CW2]), 256'(15));
        end
        hs2.pndng[1] = 0; hs2.pop[1] = 0;
        chk("sat_17", 256'(xfer_cnt2[CW2 +: CW2]), 256'(15));
        chk("sat_ch0", 256'(xfer_cnt2[0 +: CW2]), 256'(0));
        chk("sat_irq", 256'(irq2), 256'(0));

        // randomized traffic against the model
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        mdl_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int c = 0; c < CH; c++) begin
                logic [63:0] r;
                if (hs.pndng[c]) hs.pndng[c] = ($urandom_range(99) < 95);
                else hs.pndng[c] = ($urandom_range(99) < 10);
                hs.pop[c] = hs.pndng[c] ? ($urandom_range(99) < 3)
                                        : ($urandom_range(99) < 2);
                if ($urandom_range(99) < 2) begin
                    r = {$urandom(), $urandom()};
                    hs.data[c*PW +: PW] = r[PW-1:0];
                end
            end
            clr_err = ($urandom_range(99) < 1);
            clr_cnt = ($urandom_range(199) < 1);
            tick();
            mdl_step();
            mdl_check(cyc);
        end
        clr_err = 0; clr_cnt = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mesh_hs_monitor.md
MESH_HS_MONITOR -- requirements
Module: mesh_hs_monitor

Interface
REQ-001 Parameter CHANNELS, default 16: number of monitored pndng/pop handshake channels, legal range 1..64.
REQ-002 Parameter PCKG_SZ, default 40: packet width in bits per channel.
REQ-003 Parameter TIMEOUT, default 50: maximum number of consecutive pending cycles without pop, legal range 2..1023.
REQ-004 Parameter CNT_W, default 16: width of each per-channel transfer counter.
REQ-005 Port: clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 Port: reset, input, 1, asynchronous, active-high reset.
REQ-007 Port: pndng, input, CHANNELS, per-channel data-pending request.
REQ-008 Port: pop, input, CHANNELS, per-channel consumer pop.
REQ-009 Port: data, input, CHANNELS*PCKG_SZ, per-channel packet; channel i occupies bits [i*PCKG_SZ +: PCKG_SZ].
REQ-010 Port: clr_err, input, 1, synchronous clear of all sticky error flags.
REQ-011 Port: clr_cnt, input, 1, synchronous clear of all transfer counters.
REQ-012 Port: err_timeout, output, CHANNELS, sticky flag: pending exceeded TIMEOUT.
REQ-013 Port: err_unstable, output, CHANNELS, sticky flag: data changed while pending.
REQ-014 Port: err_drop, output, CHANNELS, sticky flag: pndng withdrawn before pop.
REQ-015 Port: err_spurious, output, CHANNELS, sticky flag: pop asserted with pndng low.
REQ-016 Port: xfer_cnt, output, CHANNELS*CNT_W, per-channel saturating transfer count, packed like data.
REQ-017 Port: irq, output, 1, OR of all bits of the four error flag vectors.

Function
REQ-018 Each channel SHALL run an independent FSM with states IDLE, WAIT and TOUT, plus a 10-bit wait counter and a PCKG_SZ data capture register.
REQ-019 IDLE with pndng=1 and pop=1: count one transfer and remain in IDLE.
REQ-020 IDLE with pndng=1 and pop=0: capture data, set wait counter to 1, and go to WAIT.
REQ-021 IDLE with pndng=0 and pop=1: set err_spurious and remain in IDLE.
REQ-022 WAIT or TOUT with pop=1: count one transfer and go to IDLE; if pndng is still high on the next edge, that edge starts a new request.
REQ-023 WAIT or TOUT with pndng=0 and pop=0: set err_drop and go to IDLE.
REQ-024 WAIT or TOUT with pndng=1 and data different from the captured value: set err_unstable; state handling is unchanged.
REQ-025 WAIT with pndng=1 and pop=0: increment the wait counter; when it reaches TIMEOUT, set err_timeout and go to TOUT.
- err_timeout is visible after the TIMEOUT-th consecutive edge with pndng=1 and pop=0.
REQ-026 TOUT with pndng=1 and pop=0: hold state; the wait counter stops.
REQ-027 Transfer counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-028 clr_cnt SHALL zero all counters.
- If a transfer occurs on the same edge as clr_cnt, the counter becomes 1.
REQ-029 clr_err SHALL zero all sticky flags.
- If an error event occurs on the same edge as clr_err, that flag is set (set wins).
REQ-030 All flag and counter outputs SHALL be registered.
- Latency: one edge from the sampled event to the output.
- irq is a combinational OR of the registered flags.

Reset
REQ-031 On reset=1, all FSMs SHALL go to IDLE immediately, independent of clk.
- Wait counters, capture registers, xfer_cnt and all flags go to 0; irq goes to 0.
REQ-032 A reset asserted mid-WAIT SHALL discard the pending request with no error recorded.
REQ-033 After reset deasserts, the first rising edge SHALL evaluate inputs from the IDLE state.

Structure
REQ-034 Package mesh_hs_pkg SHALL hold:
- the hs_state_t enum (IDLE, WAIT, TOUT);
- the wait-counter width constant WAIT_W=10;
- the error index constants ERR_TOUT=0, ERR_UNST=1, ERR_DROP=2, ERR_SPUR=3.
REQ-035 Per-channel logic SHALL live in sub-module mesh_hs_chan.
- mesh_hs_monitor instantiates CHANNELS copies in a generate loop and computes irq.

Verification
REQ-036 ch3: pndng rises, pop pulses 10 cycles later -> xfer_cnt[3]=1, no flags set, irq=0.
REQ-037 ch0: pndng held high, no pop -> err_timeout[0]=1 and irq=1 after the 50th edge; pop at cycle 60 -> xfer_cnt[0]=1; then clr_err -> err_timeout[0]=0, irq=0.
REQ-038 ch5: data changes from 0x0A to 0x0B at cycle 4 of WAIT -> err_unstable[5]=1. ch6: pndng drops at cycle 3 without pop -> err_drop[6]=1. ch7: pop with pndng=0 -> err_spurious[7]=1.
REQ-039 ch2: reset pulsed during WAIT at cycle 20 -> all outputs 0 with no error. Then CNT_W=4 with 17 back-to-back transfers on ch1 -> xfer_cnt[1]=15.
REQ-040 clr_err coincides with a new drop event on ch9 -> err_drop[9]=1. clr_cnt coincides with a transfer on ch9 -> xfer_cnt[9]=1.
